// File: rtl/mem_arbiter.sv
// Sequencer sharing one single-port memory between instruction fetch and data
// access; stalls the pipeline until both accesses of a pipeline cycle complete.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcf,
  input  logic        memreadm,
  input  logic        memwritem,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] rdf,
  output logic [31:0] rdm,
  output logic        memstall,
  output logic        memerr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] stallcnt
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] ARB   = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  logic [2:0]    state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [31:0]   rdf_nx, rdm_nx, mem_addr_nx, mem_wdata_nx, stallcnt_nx;
  logic          memstall_nx, memerr_nx, mem_req_nx, mem_we_nx;
  logic          timed_out;

  assign timed_out = (wcnt == CW'(TIMEOUT - 1));

  // Next-state and next-output decode; request fields are launched on entry
  // into a request state and held until the completing edge.
  always_comb begin
    state_nx     = state;
    wcnt_nx      = wcnt;
    rdf_nx       = rdf;
    rdm_nx       = rdm;
    memstall_nx  = 1'b1;
    memerr_nx    = memerr;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    stallcnt_nx  = stallcnt + 32'(memstall);

    case (state)
      ARB: begin
        wcnt_nx    = '0;
        mem_req_nx = 1'b1;
        if (memreadm || memwritem) begin
          state_nx     = DATA;
          mem_we_nx    = memwritem;
          mem_addr_nx  = {aluoutm[31:2], 2'b00};
          mem_wdata_nx = writedatam;
        end else begin
          state_nx     = FETCH;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = {pcf[31:2], 2'b00};
          mem_wdata_nx = '0;
        end
      end
      DATA: begin
        if (mem_ready) begin
          if (!mem_we) rdm_nx = mem_rdata;
          state_nx     = FETCH;
          wcnt_nx      = '0;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = {pcf[31:2], 2'b00};
          mem_wdata_nx = '0;
        end else if (timed_out) begin
          state_nx   = ERR;
          memerr_nx  = 1'b1;
          mem_req_nx = 1'b0;
          mem_we_nx  = 1'b0;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end
      FETCH: begin
        if (mem_ready) begin
          rdf_nx      = mem_rdata;
          state_nx    = DONE;
          memstall_nx = 1'b0;
          mem_req_nx  = 1'b0;
        end else if (timed_out) begin
          state_nx   = ERR;
          memerr_nx  = 1'b1;
          mem_req_nx = 1'b0;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end
      DONE: begin
        state_nx   = ARB;
        mem_req_nx = 1'b0;
      end
      ERR: begin
        mem_req_nx = 1'b0;
        memerr_nx  = 1'b1;
      end
      default: begin
        state_nx   = ARB;
        mem_req_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      wcnt      <= '0;
      rdf       <= '0;
      rdm       <= '0;
      memstall  <= 1'b1;
      memerr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      stallcnt  <= '0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      rdf       <= rdf_nx;
      rdm       <= rdm_nx;
      memstall  <= memstall_nx;
      memerr    <= memerr_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      stallcnt  <= stallcnt_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays the memory and checks
// each pipeline cycle against a request-list model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcf, aluoutm, writedatam, mem_rdata;
  logic        memreadm, memwritem, mem_ready;
  logic [31:0] rdf, rdm, mem_addr, mem_wdata, stallcnt;
  logic        memstall, memerr, mem_req, mem_we;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rdm = '0;
  logic [31:0] model_rdf = '0;
  int          model_stall = 0;

  typedef struct {
    logic [31:0] pc;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wd;
    int          wait_d;
    int          wait_f;
    logic [31:0] dat_d;
    logic [31:0] dat_f;
    int          exp_clocks;
    logic [31:0] exp_rdf;
    logic [31:0] exp_rdm;
  } vec_t;

  vec_t vecs[6];

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pcf(pcf), .memreadm(memreadm),
    .memwritem(memwritem), .aluoutm(aluoutm), .writedatam(writedatam),
    .rdf(rdf), .rdm(rdm), .memstall(memstall), .memerr(memerr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stallcnt(stallcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pipeline cycle starting in ARB; memory answers each expected request
  // after the given number of wait cycles. Ends one clock after DONE.
  task automatic run_cycle(input logic [31:0] pc, input logic rd, input logic wr,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input int wait_d, input int wait_f,
                           input logic [31:0] dat_d, input logic [31:0] dat_f,
                           output int clocks);
    logic [31:0] ra[2], rw[2], rdat[2];
    logic        rwe[2];
    int          rwait[2];
    int          n, idx, w, exp_clocks;
    n = 0;
    if (rd || wr) begin
      ra[0] = {alu[31:2], 2'b00}; rwe[0] = wr; rw[0] = wd;
      rwait[0] = wait_d; rdat[0] = dat_d; n = 1;
    end
    ra[n] = {pc[31:2], 2'b00}; rwe[n] = 1'b0; rw[n] = '0;
    rwait[n] = wait_f; rdat[n] = dat_f; n++;
    exp_clocks = 2 + n;
    for (int i = 0; i < n; i++) exp_clocks += rwait[i];
    if (rd && !wr) model_rdm = dat_d;
    model_rdf = dat_f;

    pcf = pc; memreadm = rd; memwritem = wr; aluoutm = alu; writedatam = wd;
    clocks = 1; idx = 0; w = 0;
    while (memstall && clocks < 40) begin
      if (mem_req) begin
        if (idx < n) begin
          chk("req_addr", mem_addr, ra[idx]);
          chk("req_we", {31'b0, mem_we}, {31'b0, rwe[idx]});
          chk("req_wdata", mem_wdata, rw[idx]);
          if (w == rwait[idx]) begin
            mem_ready = 1'b1; mem_rdata = rdat[idx]; idx++; w = 0;
          end else begin
            mem_ready = 1'b0; mem_rdata = $urandom; w++;
          end
        end else begin
          chk("unexpected_req", {31'b0, mem_req}, 32'd0);
          mem_ready = 1'b1; mem_rdata = $urandom;
        end
      end else begin
        mem_ready = 1'($urandom); mem_rdata = $urandom;
      end
      tick();
      clocks++;
    end
    chk("done_reached", {31'b0, memstall}, 32'd0);
    chk("req_served", 32'(idx), 32'(n));
    chk("clocks", 32'(clocks), 32'(exp_clocks));
    chk("rdf", rdf, model_rdf);
    chk("rdm", rdm, model_rdm);
    chk("done_req", {31'b0, mem_req}, 32'd0);
    chk("memerr", {31'b0, memerr}, 32'd0);
    model_stall += exp_clocks - 1;
    chk("stallcnt", stallcnt, 32'(model_stall));
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    tick();
    chk("stall_after_done", {31'b0, memstall}, 32'd1);
    chk("rdf_hold", rdf, model_rdf);
  endtask

  initial begin
    int clocks, reqs, edges;
    vecs[0] = '{32'h00400004, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h8C080000, 3, 32'h8C080000, 32'h0};
    vecs[1] = '{32'h00400008, 1'b1, 1'b0, 32'h10000006, 32'h0, 0, 0, 32'h12345678, 32'h00000000, 4, 32'h0, 32'h12345678};
    vecs[2] = '{32'h0040000C, 1'b0, 1'b1, 32'h10000010, 32'hDEADBEEF, 3, 0, 32'h0BADF00D, 32'h11111111, 7, 32'h11111111, 32'h12345678};
    vecs[3] = '{32'h00400010, 1'b1, 1'b1, 32'h20000003, 32'hCAFEF00D, 0, 0, 32'h55555555, 32'h22222222, 4, 32'h22222222, 32'h12345678};
    vecs[4] = '{32'h00400016, 1'b0, 1'b0, 32'h0, 32'h0, 0, 7, 32'h0, 32'h33333333, 10, 32'h33333333, 32'h12345678};
    vecs[5] = '{32'h00400018, 1'b1, 1'b0, 32'h3000000C, 32'h0, 7, 2, 32'hA5A5A5A5, 32'h44444444, 13, 32'h44444444, 32'hA5A5A5A5};

    reset = 1'b1; pcf = '0; memreadm = 1'b0; memwritem = 1'b0; aluoutm = '0;
    writedatam = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, memstall}, 32'd1);
    chk("rst_err", {31'b0, memerr}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdf", rdf, 32'd0);
    chk("rst_rdm", rdm, 32'd0);
    chk("rst_stallcnt", stallcnt, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_cycle(vecs[i].pc, vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].wd,
                vecs[i].wait_d, vecs[i].wait_f, vecs[i].dat_d, vecs[i].dat_f, clocks);
      chk($sformatf("vec%0d_clocks", i), 32'(clocks), 32'(vecs[i].exp_clocks));
      chk($sformatf("vec%0d_rdf", i), rdf, vecs[i].exp_rdf);
      chk($sformatf("vec%0d_rdm", i), rdm, vecs[i].exp_rdm);
    end

    for (int k = 0; k < 40; k++) begin
      run_cycle($urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)),
                $urandom, $urandom, clocks);
    end

    // Asynchronous reset in the middle of a stalled fetch.
    memreadm = 1'b0; memwritem = 1'b0; pcf = 32'h00400100; mem_ready = 1'b0;
    tick();
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_req", {31'b0, mem_req}, 32'd0);
    chk("async_stall", {31'b0, memstall}, 32'd1);
    chk("async_rdf", rdf, 32'd0);
    chk("async_rdm", rdm, 32'd0);
    chk("async_stallcnt", stallcnt, 32'd0);
    tick();
    reset = 1'b0;
    model_rdm = '0; model_rdf = '0; model_stall = 0;
    run_cycle(32'h00400004, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h8C080000, clocks);

    // Timeout: memory never answers the fetch.
    mem_ready = 1'b0; reqs = 0; edges = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      edges++;
      if (!mem_req) break;
      reqs++;
    end
    chk("tmo_req_cycles", 32'(reqs), 32'(TMO));
    chk("tmo_err", {31'b0, memerr}, 32'd1);
    chk("tmo_stall", {31'b0, memstall}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      mem_ready = 1'b1;
      tick();
      edges++;
      chk("err_sticky", {31'b0, memerr}, 32'd1);
      chk("err_req", {31'b0, mem_req}, 32'd0);
      chk("err_stall", {31'b0, memstall}, 32'd1);
    end
    chk("err_stallcnt", stallcnt, 32'(model_stall + edges));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares one single-port unified memory between the pipeline's instruction fetch (F stage) and data access (M stage). It freezes the whole pipeline with `memstall` until both accesses for the current pipeline cycle are done. It returns the fetched instruction and the load data from hold registers. It sits between the pipeline datapath and the memory, beside the hazard unit; the hazard unit ORs `memstall` into every stall and enable.

## Interface
- `TIMEOUT`, default 256: maximum cycles one memory request may wait for `mem_ready` before it is declared an error.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pcf` in 32: fetch byte address. Stable while `memstall`=1.
- `memreadm` in 1: M stage holds a load. Stable while `memstall`=1.
- `memwritem` in 1: M stage holds a store. Stable while `memstall`=1.
- `aluoutm` in 32: data byte address.
- `writedatam` in 32: store data.
- `rdf` out 32: fetched instruction (hold register).
- `rdm` out 32: load data (hold register).
- `memstall` out 1: when 1, the pipeline must not advance.
- `memerr` out 1: sticky timeout flag.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data. Valid in the cycle `mem_ready`=1.
- `mem_ready` in 1: completes the current request at this rising edge.
- `stallcnt` out 32: count of cycles with `memstall`=1 since reset. Wraps.

## Operation
- Moore FSM with states ARB, DATA, FETCH, DONE, ERR. All memory-side outputs and `memstall` are decoded from registered state only.
- ARB: `mem_req`=0, `memstall`=1.
  - Next state is DATA if `memreadm|memwritem`, else FETCH.
  - If both `memreadm` and `memwritem` are 1, treat the access as a write.
- DATA: `mem_req`=1, `mem_we`=`memwritem`, `mem_addr` from `aluoutm`, `mem_wdata`=`writedatam`, `memstall`=1.
  - On `mem_ready`: if the access is a read, load `rdm` from `mem_rdata`. Then go to FETCH.
  - A store leaves `rdm` unchanged.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr` from `pcf`, `mem_wdata`=0, `memstall`=1.
  - On `mem_ready`: load `rdf` from `mem_rdata`, then go to DONE.
- DONE: `mem_req`=0, `memstall`=0. The pipeline advances on this edge. Next state is ARB.
- Data always has priority over fetch within a pipeline cycle. Fetch is never skipped.
- Wait counter (width `$clog2(TIMEOUT)+1`):
  - Clears on entry to DATA or FETCH.
  - Increments each cycle in DATA or FETCH while `mem_ready`=0.
  - If it reaches `TIMEOUT`-1 with `mem_ready`=0: go to ERR and set `memerr`=1.
- ERR: `mem_req`=0, `memstall`=1, `memerr`=1. Leaves ERR only on `reset`.
- `stallcnt` increments every cycle `memstall`=1, including ERR.

## Timing
- Reset values (asynchronous):
  - state = ARB
  - `rdf`=0, `rdm`=0
  - `memstall`=1, `memerr`=0
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `stallcnt`=0, wait counter = 0
- Reset asserted mid-request drops `mem_req` immediately. The memory must tolerate an abandoned request.
- Memory handshake: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay constant from request entry until the edge where `mem_ready`=1. `mem_ready` sampled while `mem_req`=0 is ignored.
- Latency with zero-wait memory (`mem_ready` tied to 1):
  - No data access: 3 clocks per pipeline advance (ARB, FETCH, DONE).
  - Load or store: 4 clocks per pipeline advance (ARB, DATA, FETCH, DONE).
- Each wait cycle with `mem_ready`=0 adds 1 clock.
- `rdf` and `rdm` change only on a completing edge. They are stable through DONE and until the next completion.
- Timeout boundary: `mem_ready` arriving on the very cycle the counter hits `TIMEOUT`-1 counts as success. Ready has priority over timeout.
- `memstall` is 0 for exactly one clock per DONE. It is never 0 in any two consecutive cycles.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-FETCH. Required: `mem_req`=0 and `memstall`=1 without waiting for a clock edge; `rdf`=0, `rdm`=0, `stallcnt`=0.
- **Fetch only, zero-wait.** `mem_ready`=1, `pcf`=0x00400004, `mem_rdata`=0x8C080000, no data access. Required: states ARB, FETCH, DONE; `mem_addr`=0x00400004 with `mem_we`=0 in FETCH; `rdf`=0x8C080000 in DONE; `memstall` pattern 1,1,0; `stallcnt`=2 after one pipeline cycle.
- **Load then fetch.** `memreadm`=1, `aluoutm`=0x10000006, memory returns 0x12345678 then 0x00000000. Required: the first request is at `mem_addr`=0x10000004 with `mem_we`=0; `rdm`=0x12345678; the fetch follows as the second request; 4 clocks per advance.
- **Store with wait states.** `memwritem`=1, `writedatam`=0xDEADBEEF, `mem_ready` low for 3 cycles then high. Required: `mem_we`=1 with address and data held for all 4 request cycles; `rdm` unchanged; the fetch then proceeds.
- **Timeout.** `TIMEOUT`=8, `mem_ready`=0 forever. Required: ERR is entered after 8 request cycles; `memerr`=1 sticky; `mem_req`=0; `memstall`=1 until reset. Variant: `mem_ready`=1 on the 8th request cycle gives normal completion with no error.
- **Both load and store set.** `memreadm`=`memwritem`=1. Required: a write is issued (`mem_we`=1) and `rdm` is unchanged.
